// File: rtl/time_entry_loader.sv
// time_entry_loader: keypad digit buffer and load/run sequencer for the MM:SS BCD down-counter chain.
// Latency: all outputs registered, 1 cycle after the key strobe edge; loadn held low LOAD_CYCLES cycles.
// Backpressure: none; one key acted on per cycle, keys arriving during LOAD are dropped.
// Optional feature macro QUICK_START_EN: START on an empty entry loads 30 s, START while running adds 30 s.
module time_entry_loader #(
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_SEC_TENS = 5,
  parameter int LOAD_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    timer_zero,
  output logic [4*NUM_DIGITS-1:0] data,
  output logic                    loadn,
  output logic                    cnt_en,
  output logic                    ctr_clrn,
  output logic [2:0]              digit_count,
  output logic                    entry_err,
  output logic                    running
);

  localparam int         DW       = 4 * NUM_DIGITS;
  localparam logic [3:0] MAX_ST4  = MAX_SEC_TENS[3:0];
  localparam logic [2:0] ND3      = NUM_DIGITS[2:0];
  localparam logic [1:0] LC_INIT  = 2'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_LOAD, S_RUN, S_PAUSE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      load_cnt_q, load_cnt_d;
  logic            loadn_q, loadn_d;
  logic            cnt_en_q, cnt_en_d;
  logic            ctr_clrn_q, ctr_clrn_d;
  logic            entry_err_q, entry_err_d;
  logic            running_q, running_d;

  logic is_digit, is_cancel, is_start, is_pause, start_bad;

  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_cancel = key_valid && (key_code == 4'hA);
  assign is_start  = key_valid && (key_code == 4'hB);
  assign is_pause  = key_valid && (key_code == 4'hC);
  // An entry is unusable if the seconds-tens digit is out of range or nothing nonzero was typed.
  assign start_bad = (data_q[7:4] > MAX_ST4) || (data_q == '0);

`ifdef QUICK_START_EN
  localparam logic [DW-1:0] PRESET_30S = DW'(8'h30);

  // +30 s on the buffered value: bump seconds-tens, wrap past the limit and ripple a BCD carry
  // through the minutes digits; overflow of the top digit pins the minutes at all nines.
  function automatic logic [DW-1:0] add_30s(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic [4:0]    tens;
    logic          carry;
    r     = d;
    tens  = {1'b0, d[7:4]} + 5'd3;
    carry = 1'b0;
    if (tens > {1'b0, MAX_ST4}) begin
      tens  = tens - 5'd6;
      carry = 1'b1;
    end
    r[7:4] = tens[3:0];
    for (int i = 2; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) begin
      for (int i = 2; i < NUM_DIGITS; i++) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction
`endif

  // Next-state and registered-output decode; one key handled per cycle.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    load_cnt_d  = load_cnt_q;
    loadn_d     = 1'b1;
    cnt_en_d    = cnt_en_q;
    ctr_clrn_d  = 1'b1;
    entry_err_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_ENTRY: begin
        if (is_digit) begin
          data_d  = {data_q[DW-5:0], key_code};
          cnt_d   = (cnt_q < ND3) ? cnt_q + 3'd1 : cnt_q;
          state_d = S_ENTRY;
        end else if (is_cancel && state_q == S_ENTRY) begin
          data_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (is_start) begin
`ifdef QUICK_START_EN
          if (state_q == S_IDLE && cnt_q == 3'd0) begin
            data_d     = PRESET_30S;
            state_d    = S_LOAD;
            loadn_d    = 1'b0;
            load_cnt_d = LC_INIT;
          end else
`endif
          if (start_bad) begin
            entry_err_d = 1'b1;
          end else begin
            state_d    = S_LOAD;
            loadn_d    = 1'b0;
            load_cnt_d = LC_INIT;
          end
        end
      end
      S_LOAD: begin
        if (load_cnt_q == 2'd0) begin
          state_d  = S_RUN;
          cnt_en_d = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q - 2'd1;
          loadn_d    = 1'b0;
        end
      end
      S_RUN, S_PAUSE: begin
        if (is_cancel) begin
          ctr_clrn_d = 1'b0;
          data_d     = '0;
          cnt_d      = '0;
          cnt_en_d   = 1'b0;
          state_d    = S_IDLE;
        end else if (state_q == S_RUN) begin
          if (timer_zero) begin
            data_d   = '0;
            cnt_d    = '0;
            cnt_en_d = 1'b0;
            state_d  = S_IDLE;
          end else if (is_pause) begin
            cnt_en_d = 1'b0;
            state_d  = S_PAUSE;
`ifdef QUICK_START_EN
          end else if (is_start) begin
            data_d     = add_30s(data_q);
            cnt_en_d   = 1'b0;
            loadn_d    = 1'b0;
            load_cnt_d = LC_INIT;
            state_d    = S_LOAD;
`endif
          end
        end else if (is_start) begin
          cnt_en_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  // State and output registers; reset drops any load in progress immediately.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      load_cnt_q  <= '0;
      loadn_q     <= 1'b1;
      cnt_en_q    <= 1'b0;
      ctr_clrn_q  <= 1'b1;
      entry_err_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      load_cnt_q  <= load_cnt_d;
      loadn_q     <= loadn_d;
      cnt_en_q    <= cnt_en_d;
      ctr_clrn_q  <= ctr_clrn_d;
      entry_err_q <= entry_err_d;
      running_q   <= running_d;
    end
  end

  assign data        = data_q;
  assign loadn       = loadn_q;
  assign cnt_en      = cnt_en_q;
  assign ctr_clrn    = ctr_clrn_q;
  assign digit_count = cnt_q;
  assign entry_err   = entry_err_q;
  assign running     = running_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Bench for time_entry_loader: directed vector table, reset corner cases, randomized run vs reference model.
module tb_time_entry_loader;

  logic        clk = 1'b0;
  logic        clrn, key_valid, timer_zero;
  logic [3:0]  key_code;
  logic [15:0] data;
  logic        loadn, cnt_en, ctr_clrn, entry_err, running;
  logic [2:0]  digit_count;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  time_entry_loader dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
    .timer_zero(timer_zero), .data(data), .loadn(loadn), .cnt_en(cnt_en),
    .ctr_clrn(ctr_clrn), .digit_count(digit_count), .entry_err(entry_err),
    .running(running)
  );

  typedef struct {
    logic        v;
    logic [3:0]  code;
    logic        tz;
    logic [15:0] d;
    logic [2:0]  c;
    logic        ld, en, clr, err, run;
  } vec_t;
  vec_t vt[$];

  task automatic vec(input logic v, input logic [3:0] code, input logic tz, input logic [15:0] d,
                     input logic [2:0] c, input logic ld, en, clr, err, run);
    vec_t r;
    r.v = v; r.code = code; r.tz = tz; r.d = d; r.c = c;
    r.ld = ld; r.en = en; r.clr = clr; r.err = err; r.run = run;
    vt.push_back(r);
  endtask

  task automatic check(input string name, input logic [15:0] ed, input logic [2:0] ec,
                       input logic eld, een, eclr, eerr, erun);
    n_checks++;
    if (data !== ed || digit_count !== ec || loadn !== eld || cnt_en !== een ||
        ctr_clrn !== eclr || entry_err !== eerr || running !== erun) begin
      n_err++;
      $display("FAIL %s: got data=%h cnt=%0d loadn=%b en=%b clrn=%b err=%b run=%b, want data=%h cnt=%0d loadn=%b en=%b clrn=%b err=%b run=%b",
               name, data, digit_count, loadn, cnt_en, ctr_clrn, entry_err, running,
               ed, ec, eld, een, eclr, eerr, erun);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 ns after the edge that consumed them.
  task automatic cyc(input logic v, input logic [3:0] code, input logic tz);
    key_valid = v; key_code = code; timer_zero = tz;
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_code = 4'h0; timer_zero = 1'b0;
  endtask

  // ---------------- reference model: digits as integers, mode as a plain number ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4;
  int   m_mode, m_cnt, m_left;
  int   m_dig[4];
  logic m_loadn, m_en, m_clrn, m_err;

  function automatic int m_total_sec();
    return (m_dig[3] * 10 + m_dig[2]) * 60 + m_dig[1] * 10 + m_dig[0];
  endfunction

  function automatic logic [15:0] m_data();
    return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_cnt = 0; m_left = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_loadn = 1'b1; m_en = 1'b0; m_clrn = 1'b1; m_err = 1'b0;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_cnt = 0; m_en = 1'b0; m_mode = M_IDLE;
  endtask

  task automatic m_enter_load();
    m_mode = M_LOAD; m_left = 1; m_loadn = 1'b0; m_en = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c, input logic tz);
    bit dk = v && (c <= 4'd9);
    bit ca = v && (c == 4'hA);
    bit st = v && (c == 4'hB);
    bit pa = v && (c == 4'hC);
    m_err = 1'b0; m_clrn = 1'b1; m_loadn = 1'b1;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (dk) begin
          for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
          m_dig[0] = int'(c);
          if (m_cnt < 4) m_cnt++;
          m_mode = M_ENTRY;
        end else if (ca && m_mode == M_ENTRY) begin
          m_clear();
        end else if (st) begin
`ifdef QUICK_START_EN
          if (m_mode == M_IDLE && m_cnt == 0) begin
            m_dig[1] = 3;
            m_enter_load();
          end else
`endif
          if (m_dig[1] > 5 || m_total_sec() == 0) m_err = 1'b1;
          else m_enter_load();
        end
      end
      M_LOAD: begin
        if (m_left == 1) begin m_mode = M_RUN; m_en = 1'b1; end
        else begin m_left--; m_loadn = 1'b0; end
      end
      M_RUN: begin
        if (ca) begin m_clear(); m_clrn = 1'b0; end
        else if (tz) m_clear();
        else if (pa) begin m_mode = M_PAUSE; m_en = 1'b0; end
`ifdef QUICK_START_EN
        else if (st) begin
          int t;
          bit carry;
          t = m_dig[1] + 3; carry = 0;
          if (t > 5) begin t = t - 6; carry = 1; end
          m_dig[1] = t;
          for (int i = 2; i < 4; i++)
            if (carry) begin
              if (m_dig[i] == 9) m_dig[i] = 0;
              else begin m_dig[i]++; carry = 0; end
            end
          if (carry) begin m_dig[2] = 9; m_dig[3] = 9; end
          m_enter_load();
        end
`endif
      end
      M_PAUSE: begin
        if (ca) begin m_clear(); m_clrn = 1'b0; end
        else if (st) begin m_mode = M_RUN; m_en = 1'b1; end
      end
      default: m_reset();
    endcase
  endtask

  task automatic check_model(input string name);
    check(name, m_data(), 3'(m_cnt), m_loadn, m_en, m_clrn, m_err,
          (m_mode == M_RUN) || (m_mode == M_PAUSE));
  endtask

  initial begin
    // v code tz | data cnt loadn en clrn err run
    vec(1, 4'h1, 0, 16'h0001, 1, 1, 0, 1, 0, 0);
    vec(1, 4'h3, 0, 16'h0013, 2, 1, 0, 1, 0, 0);
    vec(1, 4'h0, 0, 16'h0130, 3, 1, 0, 1, 0, 0);
    vec(1, 4'hB, 0, 16'h0130, 3, 0, 0, 1, 0, 0);
    vec(0, 4'h0, 0, 16'h0130, 3, 1, 1, 1, 0, 1);
    vec(1, 4'hC, 0, 16'h0130, 3, 1, 0, 1, 0, 1);
    vec(1, 4'hB, 0, 16'h0130, 3, 1, 1, 1, 0, 1);
    vec(1, 4'h5, 0, 16'h0130, 3, 1, 1, 1, 0, 1);
    vec(0, 4'h0, 1, 16'h0000, 0, 1, 0, 1, 0, 0);
    vec(1, 4'h7, 0, 16'h0007, 1, 1, 0, 1, 0, 0);
    vec(1, 4'h5, 0, 16'h0075, 2, 1, 0, 1, 0, 0);
    vec(1, 4'h9, 0, 16'h0759, 3, 1, 0, 1, 0, 0);
    vec(1, 4'h0, 0, 16'h7590, 4, 1, 0, 1, 0, 0);
    vec(1, 4'hB, 0, 16'h7590, 4, 1, 0, 1, 1, 0);
    vec(0, 4'h0, 0, 16'h7590, 4, 1, 0, 1, 0, 0);
    vec(1, 4'hA, 0, 16'h0000, 0, 1, 0, 1, 0, 0);
    vec(1, 4'hA, 0, 16'h0000, 0, 1, 0, 1, 0, 0);
    vec(1, 4'h1, 0, 16'h0001, 1, 1, 0, 1, 0, 0);
    vec(1, 4'h2, 0, 16'h0012, 2, 1, 0, 1, 0, 0);
    vec(1, 4'h3, 0, 16'h0123, 3, 1, 0, 1, 0, 0);
    vec(1, 4'h4, 0, 16'h1234, 4, 1, 0, 1, 0, 0);
    vec(1, 4'h5, 0, 16'h2345, 4, 1, 0, 1, 0, 0);
    vec(1, 4'hB, 0, 16'h2345, 4, 0, 0, 1, 0, 0);
    vec(0, 4'h0, 0, 16'h2345, 4, 1, 1, 1, 0, 1);
    vec(1, 4'hA, 1, 16'h0000, 0, 1, 0, 0, 0, 0);
    vec(0, 4'h0, 0, 16'h0000, 0, 1, 0, 1, 0, 0);
    vec(1, 4'h0, 0, 16'h0000, 1, 1, 0, 1, 0, 0);
    vec(1, 4'hB, 0, 16'h0000, 1, 1, 0, 1, 1, 0);
    vec(1, 4'hA, 0, 16'h0000, 0, 1, 0, 1, 0, 0);
    vec(1, 4'h6, 0, 16'h0006, 1, 1, 0, 1, 0, 0);
    vec(1, 4'h0, 0, 16'h0060, 2, 1, 0, 1, 0, 0);
    vec(1, 4'hB, 0, 16'h0060, 2, 1, 0, 1, 1, 0);
    vec(1, 4'hE, 0, 16'h0060, 2, 1, 0, 1, 0, 0);
    vec(1, 4'hA, 0, 16'h0000, 0, 1, 0, 1, 0, 0);
    vec(1, 4'h5, 0, 16'h0005, 1, 1, 0, 1, 0, 0);
    vec(1, 4'h9, 0, 16'h0059, 2, 1, 0, 1, 0, 0);
    vec(1, 4'hB, 0, 16'h0059, 2, 0, 0, 1, 0, 0);
    vec(0, 4'h0, 0, 16'h0059, 2, 1, 1, 1, 0, 1);
    vec(1, 4'hC, 0, 16'h0059, 2, 1, 0, 1, 0, 1);
    vec(0, 4'h0, 1, 16'h0059, 2, 1, 0, 1, 0, 1);
    vec(1, 4'hA, 0, 16'h0000, 0, 1, 0, 0, 0, 0);
    vec(0, 4'h0, 0, 16'h0000, 0, 1, 0, 1, 0, 0);

    key_valid = 1'b0; key_code = 4'h0; timer_zero = 1'b0;
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #10;
    check("reset", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 clrn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].v, vt[i].code, vt[i].tz);
      check($sformatf("vec%0d", i), vt[i].d, vt[i].c, vt[i].ld, vt[i].en, vt[i].clr, vt[i].err, vt[i].run);
    end

`ifdef QUICK_START_EN
    cyc(1, 4'hB, 0); check("qs_preset", 16'h0030, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 4'h0, 0); check("qs_run", 16'h0030, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1, 4'hA, 0); check("qs_cancel", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 4'h0, 0); cyc(1, 4'h0, 0); cyc(1, 4'h5, 0); cyc(1, 4'h0, 0);
    check("qs_entry", 16'h0050, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1, 4'hB, 0); cyc(0, 4'h0, 0);
    check("qs_run2", 16'h0050, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1, 4'hB, 0); check("qs_add30", 16'h0120, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 4'h0, 0); check("qs_back_run", 16'h0120, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1, 4'hA, 0); cyc(0, 4'h0, 0);
`else
    cyc(1, 4'hB, 0); check("idle_start_rejected", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 4'h0, 0);
`endif

    // Reset arriving in the middle of a load pulse.
    cyc(1, 4'h2, 0);
    cyc(1, 4'hB, 0); check("load_pre_reset", 16'h0002, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 clrn = 1'b0;
    #1 check("reset_in_load", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_held", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    clrn = 1'b1;
    cyc(0, 4'h0, 0); check("after_reset", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       v, tz;
      logic [3:0] c;
      int         r;
      v  = ($urandom_range(0, 1) == 1);
      tz = ($urandom_range(0, 15) == 0);
      r  = $urandom_range(0, 19);
      if (r < 12)      c = 4'($urandom_range(0, 9));
      else if (r < 15) c = 4'hB;
      else if (r < 17) c = 4'hC;
      else if (r < 18) c = 4'hA;
      else             c = 4'($urandom_range(13, 15));
      model_step(v, c, tz);
      cyc(v, c, tz);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
